// File: rtl/upg_mem_loader.sv
// Routes the UART programming word stream to imem/dmem and sequences the CPU reset around it.
// Optional feature: define UPG_CHECKSUM_EN to build the running checksum of accepted words.
module upg_mem_loader #(
  parameter int IMEM_DEPTH = 16384,
  parameter int DMEM_DEPTH = 16384,
  parameter int RST_HOLD   = 16
) (
  input  logic        board_clk,
  input  logic        board_rst_n,
  input  logic        upg_rst_i,
  input  logic        upg_wen_i,
  input  logic [14:0] upg_adr_i,
  input  logic [31:0] upg_dat_i,
  input  logic        upg_done_i,
  output logic        imem_wen_o,
  output logic        dmem_wen_o,
  output logic [13:0] mem_adr_o,
  output logic [31:0] mem_dat_o,
  output logic        cpu_rst_o,
  output logic [14:0] load_cnt_o,
  output logic [31:0] checksum_o,
  output logic        load_err_o
);

  // state   | meaning
  // S_RUN   | CPU running, programming idle
  // S_ARMED | programming mode entered, no word received yet
  // S_LOADING | words being written to memory
  // S_DONE  | transfer complete, further writes are errors
  // S_HOLD  | CPU held in reset for RST_HOLD cycles before run
  typedef enum logic [2:0] {
    S_RUN,
    S_ARMED,
    S_LOADING,
    S_DONE,
    S_HOLD
  } state_t;

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(RST_HOLD - 1);
  localparam logic [14:0]   IMEM_LIM    = 15'(IMEM_DEPTH);
  localparam logic [14:0]   DMEM_LIM    = 15'(DMEM_DEPTH);
  localparam logic [14:0]   CNT_MAX     = 15'h7FFF;

  state_t        r_state;
  logic [HW-1:0] r_hold_cnt;
  logic          r_cpu_rst;
  logic          r_imem_wen;
  logic          r_dmem_wen;
  logic [13:0]   r_mem_adr;
  logic [31:0]   r_mem_dat;
  logic [14:0]   r_load_cnt;
  logic          r_load_err;

  logic [14:0]   w_idx;
  logic          w_in_range;
  logic          w_can_write;
  logic          w_accept;
  logic          w_arm;

  assign w_idx      = {1'b0, upg_adr_i[13:0]};
  assign w_in_range = upg_adr_i[14] ? (w_idx < DMEM_LIM) : (w_idx < IMEM_LIM);

  // done outranks a write in ARMED, but a write coinciding with done in LOADING still lands
  assign w_can_write = ((r_state == S_ARMED) && !upg_rst_i && !upg_done_i) ||
                       ((r_state == S_LOADING) && !upg_rst_i);
  assign w_accept    = upg_wen_i && w_can_write && w_in_range;
  assign w_arm       = ((r_state == S_RUN) || (r_state == S_HOLD)) && !upg_rst_i;

  always_ff @(posedge board_clk or negedge board_rst_n) begin
    if (!board_rst_n) begin
      r_state    <= S_HOLD;
      r_hold_cnt <= HOLD_RELOAD;
      r_cpu_rst  <= 1'b1;
      r_imem_wen <= 1'b0;
      r_dmem_wen <= 1'b0;
      r_mem_adr  <= '0;
      r_mem_dat  <= '0;
      r_load_cnt <= '0;
      r_load_err <= 1'b0;
    end else begin
      r_imem_wen <= 1'b0;
      r_dmem_wen <= 1'b0;

      if (w_accept) begin
        r_imem_wen <= !upg_adr_i[14];
        r_dmem_wen <= upg_adr_i[14];
        r_mem_adr  <= upg_adr_i[13:0];
        r_mem_dat  <= upg_dat_i;
        if (r_load_cnt != CNT_MAX) begin
          r_load_cnt <= r_load_cnt + 15'd1;
        end
      end

      case (r_state)
        S_RUN: begin
          r_cpu_rst <= 1'b0;
          if (!upg_rst_i) begin
            r_state    <= S_ARMED;
            r_cpu_rst  <= 1'b1;
            r_load_cnt <= '0;
            r_load_err <= 1'b0;
          end
        end

        S_ARMED: begin
          r_cpu_rst <= 1'b1;
          if (upg_rst_i) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= HOLD_RELOAD;
          end else if (upg_done_i) begin
            r_state <= S_DONE;
            if (upg_wen_i) begin
              r_load_err <= 1'b1;
            end
          end else if (upg_wen_i) begin
            r_state <= S_LOADING;
            if (!w_in_range) begin
              r_load_err <= 1'b1;
            end
          end
        end

        S_LOADING: begin
          r_cpu_rst <= 1'b1;
          if (upg_rst_i) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= HOLD_RELOAD;
            r_load_err <= 1'b1;
          end else begin
            if (upg_wen_i && !w_in_range) begin
              r_load_err <= 1'b1;
            end
            if (upg_done_i) begin
              r_state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          r_cpu_rst <= 1'b1;
          if (upg_rst_i) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= HOLD_RELOAD;
          end else if (upg_wen_i) begin
            r_load_err <= 1'b1;
          end
        end

        S_HOLD: begin
          r_cpu_rst <= 1'b1;
          if (!upg_rst_i) begin
            r_state    <= S_ARMED;
            r_load_cnt <= '0;
            r_load_err <= 1'b0;
          end else if (r_hold_cnt == '0) begin
            r_state   <= S_RUN;
            r_cpu_rst <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
          end
        end

        default: begin
          r_state    <= S_HOLD;
          r_hold_cnt <= HOLD_RELOAD;
          r_cpu_rst  <= 1'b1;
        end
      endcase
    end
  end

`ifdef UPG_CHECKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge board_clk or negedge board_rst_n) begin
    if (!board_rst_n) begin
      r_checksum <= '0;
    end else if (w_arm) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + upg_dat_i;
    end
  end

  assign checksum_o = r_checksum;
`else
  logic w_unused_arm;
  assign w_unused_arm = w_arm;
  assign checksum_o   = '0;
`endif

  assign imem_wen_o = r_imem_wen;
  assign dmem_wen_o = r_dmem_wen;
  assign mem_adr_o  = r_mem_adr;
  assign mem_dat_o  = r_mem_dat;
  assign cpu_rst_o  = r_cpu_rst;
  assign load_cnt_o = r_load_cnt;
  assign load_err_o = r_load_err;

endmodule

// File: tb/tb_upg_mem_loader.sv
// Directed bench for upg_mem_loader: reset hold, routing, range policing, done/abort sequencing.
module tb_upg_mem_loader;

  logic        board_clk = 1'b0;
  logic        board_rst_n;
  logic        upg_rst_i;
  logic        upg_wen_i;
  logic [14:0] upg_adr_i;
  logic [31:0] upg_dat_i;
  logic        upg_done_i;
  logic        imem_wen_o;
  logic        dmem_wen_o;
  logic [13:0] mem_adr_o;
  logic [31:0] mem_dat_o;
  logic        cpu_rst_o;
  logic [14:0] load_cnt_o;
  logic [31:0] checksum_o;
  logic        load_err_o;

  int n_cmp = 0;
  int n_mis = 0;
  int n_hold;

`ifdef UPG_CHECKSUM_EN
  localparam logic [31:0] CS_TWO   = 32'hDEADBEF0;
  localparam logic [31:0] CS_THREE = 32'hDEADBF00;
  localparam logic [31:0] CS_FIVE  = 32'h00000005;
`else
  localparam logic [31:0] CS_TWO   = 32'h0;
  localparam logic [31:0] CS_THREE = 32'h0;
  localparam logic [31:0] CS_FIVE  = 32'h0;
`endif

  upg_mem_loader #(
    .IMEM_DEPTH(1024),
    .DMEM_DEPTH(2048),
    .RST_HOLD  (16)
  ) u_dut (
    .board_clk  (board_clk),
    .board_rst_n(board_rst_n),
    .upg_rst_i  (upg_rst_i),
    .upg_wen_i  (upg_wen_i),
    .upg_adr_i  (upg_adr_i),
    .upg_dat_i  (upg_dat_i),
    .upg_done_i (upg_done_i),
    .imem_wen_o (imem_wen_o),
    .dmem_wen_o (dmem_wen_o),
    .mem_adr_o  (mem_adr_o),
    .mem_dat_o  (mem_dat_o),
    .cpu_rst_o  (cpu_rst_o),
    .load_cnt_o (load_cnt_o),
    .checksum_o (checksum_o),
    .load_err_o (load_err_o)
  );

  always #5 board_clk = ~board_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge board_clk);
    #1;
  endtask

  task automatic do_write(input logic [14:0] adr, input logic [31:0] dat, input logic done);
    upg_wen_i  = 1'b1;
    upg_adr_i  = adr;
    upg_dat_i  = dat;
    upg_done_i = done;
    tick();
    upg_wen_i  = 1'b0;
    upg_done_i = 1'b0;
  endtask

  // counts edges until CPU reset drops; 64 means it never did
  task automatic wait_run(output int n);
    n = 0;
    while (cpu_rst_o && n < 64) begin
      tick();
      n++;
    end
  endtask

  always @(negedge board_clk) begin
    if (board_rst_n === 1'b1 && (imem_wen_o || dmem_wen_o)) begin
      check_val("wen_exclusive", {30'd0, imem_wen_o, dmem_wen_o} & {30'd0, dmem_wen_o, imem_wen_o}, 32'd0);
    end
  end

  initial begin
    board_rst_n = 1'b0;
    upg_rst_i   = 1'b1;
    upg_wen_i   = 1'b0;
    upg_adr_i   = '0;
    upg_dat_i   = '0;
    upg_done_i  = 1'b0;
    repeat (3) tick();

    check_val("rst_cpu_rst",  cpu_rst_o, 1);
    check_val("rst_imem_wen", imem_wen_o, 0);
    check_val("rst_dmem_wen", dmem_wen_o, 0);
    check_val("rst_adr",      mem_adr_o, 0);
    check_val("rst_dat",      mem_dat_o, 0);
    check_val("rst_cnt",      load_cnt_o, 0);
    check_val("rst_cksum",    checksum_o, 0);
    check_val("rst_err",      load_err_o, 0);

    board_rst_n = 1'b1;
    wait_run(n_hold);
    check_val("boot_hold_cycles", n_hold, 16);
    check_val("boot_cnt", load_cnt_o, 0);
    check_val("boot_err", load_err_o, 0);
    tick();
    check_val("run_cpu_rst", cpu_rst_o, 0);

    // session 1: routing, done+write, write after done
    upg_rst_i = 1'b0;
    tick();
    check_val("armed_cpu_rst", cpu_rst_o, 1);
    do_write(15'h0003, 32'hDEADBEEF, 1'b0);
    check_val("w1_imem_wen", imem_wen_o, 1);
    check_val("w1_dmem_wen", dmem_wen_o, 0);
    check_val("w1_adr", mem_adr_o, 3);
    check_val("w1_dat", mem_dat_o, 32'hDEADBEEF);
    do_write(15'h4005, 32'h00000001, 1'b0);
    check_val("w2_imem_wen", imem_wen_o, 0);
    check_val("w2_dmem_wen", dmem_wen_o, 1);
    check_val("w2_adr", mem_adr_o, 5);
    check_val("w2_cnt", load_cnt_o, 2);
    check_val("w2_cksum", checksum_o, CS_TWO);
    tick();
    check_val("idle_dmem_wen", dmem_wen_o, 0);
    check_val("idle_adr_hold", mem_adr_o, 5);
    check_val("idle_dat_hold", mem_dat_o, 1);
    do_write(15'h0010, 32'h00000010, 1'b1);
    check_val("done_w_imem_wen", imem_wen_o, 1);
    check_val("done_w_adr", mem_adr_o, 15'h0010);
    check_val("done_w_cnt", load_cnt_o, 3);
    check_val("done_w_err", load_err_o, 0);
    check_val("done_w_cksum", checksum_o, CS_THREE);
    do_write(15'h0020, 32'h00000020, 1'b0);
    check_val("late_w_imem_wen", imem_wen_o, 0);
    check_val("late_w_err", load_err_o, 1);
    check_val("late_w_cnt", load_cnt_o, 3);
    check_val("late_w_adr", mem_adr_o, 15'h0010);
    upg_rst_i = 1'b1;
    tick();
    check_val("done_hold_cpu_rst", cpu_rst_o, 1);
    wait_run(n_hold);
    check_val("done_hold_cycles", n_hold, 16);

    // session 2: aborted load
    upg_rst_i = 1'b0;
    tick();
    check_val("s2_clear_cnt", load_cnt_o, 0);
    check_val("s2_clear_err", load_err_o, 0);
    check_val("s2_clear_cksum", checksum_o, 0);
    do_write(15'h0007, 32'h00000005, 1'b0);
    check_val("s2_w_cnt", load_cnt_o, 1);
    check_val("s2_w_cksum", checksum_o, CS_FIVE);
    check_val("s2_w_err", load_err_o, 0);
    upg_rst_i = 1'b1;
    tick();
    check_val("abort_err", load_err_o, 1);
    wait_run(n_hold);
    check_val("abort_hold_cycles", n_hold, 16);
    upg_rst_i = 1'b0;
    tick();
    check_val("rearm_cnt", load_cnt_o, 0);
    check_val("rearm_err", load_err_o, 0);
    check_val("rearm_cksum", checksum_o, 0);
    check_val("rearm_cpu_rst", cpu_rst_o, 1);

    // session 3: range policing then async reset mid-load
    do_write(15'h0400, 32'h11111111, 1'b0);
    check_val("oor_imem_wen", imem_wen_o, 0);
    check_val("oor_err", load_err_o, 1);
    check_val("oor_cnt", load_cnt_o, 0);
    do_write(15'h4800, 32'h22222222, 1'b0);
    check_val("oor_dmem_wen", dmem_wen_o, 0);
    check_val("oor_d_cnt", load_cnt_o, 0);
    do_write(15'h43FF, 32'h33333333, 1'b0);
    check_val("edge_d_wen", dmem_wen_o, 1);
    check_val("edge_d_adr", mem_adr_o, 14'h03FF);
    do_write(15'h03FF, 32'h00000007, 1'b0);
    check_val("edge_i_wen", imem_wen_o, 1);
    check_val("edge_i_cnt", load_cnt_o, 2);
    #2;
    board_rst_n = 1'b0;
    #1;
    check_val("async_imem_wen", imem_wen_o, 0);
    check_val("async_cpu_rst", cpu_rst_o, 1);
    check_val("async_adr", mem_adr_o, 0);
    check_val("async_dat", mem_dat_o, 0);
    check_val("async_cnt", load_cnt_o, 0);
    check_val("async_err", load_err_o, 0);
    check_val("async_cksum", checksum_o, 0);
    upg_rst_i = 1'b1;
    tick();
    board_rst_n = 1'b1;
    wait_run(n_hold);
    check_val("post_rst_hold_cycles", n_hold, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
